// File: rtl/uart_rx_if.sv
// uart_rx_if -- signal bundle between the 8N1 receiver and its consumer.
//   RX    : serial line into the receiver (idles high)
//   OUT   : last received byte
//   VALID : OUT holds an unread byte
//   ACK   : consumer takes OUT (only meaningful while VALID = 1)
//   FERR  : one-cycle pulse, stop bit sampled low
//   OVR   : one-cycle pulse, unread byte overwritten
//   BUSY  : receiver is inside a frame (START/DATA/STOP)
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_if;
  logic       RX;
  logic [7:0] OUT;
  logic       VALID;
  logic       ACK;
  logic       FERR;
  logic       OVR;
  logic       BUSY;

  modport master (input RX, ACK, output OUT, VALID, FERR, OVR, BUSY);
  modport slave  (output RX, ACK, input OUT, VALID, FERR, OVR, BUSY);
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- asynchronous 8N1 serial receiver with a one-entry output buffer.
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   bus : uart_rx_if.master (RX/ACK in; OUT/VALID/FERR/OVR/BUSY out)
// RX is double-flopped, start bits are confirmed at mid-cell, each data and
// stop bit is sampled at its centre. A good stop bit loads OUT/VALID; a low
// stop bit pulses FERR and sends the FSM to HUNT so a held-low line (break)
// is never mistaken for a new start bit.
module uart_rx #(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic      CLK,
  input  logic      RST,
  uart_rx_if.master bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int H   = DIV / 2;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_H = CW'(H - 1);
  localparam logic [CW-1:0] CNT_D = CW'(DIV - 1);

  typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [1:0]    sync_vld_q, sync_vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    out_q, out_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic          load;

  always_comb begin
    state_d    = state_q;
    rx_meta_d  = bus.RX;
    rx_s_d     = rx_meta_q;
    // The synchroniser flops reset to 1, so rx_s is not a real line sample
    // until two edges after reset; HUNT ignores it until then.
    sync_vld_d = {sync_vld_q[0], 1'b1};
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    out_d      = out_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    load       = 1'b0;

    case (state_q)
      HUNT: if (sync_vld_q[1] && rx_s_q) state_d = IDLE;
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_H) begin
          if (rx_s_q) state_d = IDLE;  // glitch shorter than half a bit
          else begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      DATA: begin
        if (cnt_q == CNT_D) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else cnt_d = cnt_q + 1'b1;
      end
      STOP: begin
        if (cnt_q == CNT_D) begin
          if (rx_s_q) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = HUNT;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = HUNT;
    endcase

    // An ACK coinciding with a load consumes the old byte, so no overrun.
    if (load) begin
      out_d   = shreg_q;
      valid_d = 1'b1;
      ovr_d   = valid_q && !bus.ACK;
    end else if (valid_q && bus.ACK) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= HUNT;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      sync_vld_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      sync_vld_q <= sync_vld_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.OUT   = out_q;
  assign bus.VALID = valid_q;
  assign bus.FERR  = ferr_q;
  assign bus.OVR   = ovr_q;
  assign bus.BUSY  = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx at the default 104 clocks/bit.
module tb_uart_rx;
  localparam int DIV = 104;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_rx_if u_if ();

  uart_rx #(.CLK_HZ(12_000_000), .BAUD(115_200)) dut (
    .CLK(CLK), .RST(RST), .bus(u_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // free-running edge counter and pulse/edge monitors
  int   cyc = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  int   rise_cyc = 0;
  logic v_prev = 1'b0;
  int   e0_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    ferr_cnt <= ferr_cnt + int'(u_if.FERR);
    ovr_cnt  <= ovr_cnt + int'(u_if.OVR);
    if (u_if.VALID && !v_prev) rise_cyc <= cyc;
    v_prev <= u_if.VALID;
  end

  // Call just after a rising edge. Edge 0 is the first edge sampling the
  // start bit (E0). ACK is held high only for edge index ack_edge.
  // RX is left at the stop-bit value.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int ack_edge);
    logic [9:0] bits;
    int e;
    bits = {stop_v, b, 1'b0};
    e = 0;
    e0_cyc = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      u_if.RX = bits[k];
      for (int i = 0; i < DIV; i++) begin
        @(posedge CLK); #1;
        if (ack_edge >= 0 && e + 1 == ack_edge) u_if.ACK = 1'b1;
        else if (e == ack_edge) u_if.ACK = 1'b0;
        e++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge CLK); #1; end
  endtask

  task automatic pulse_ack();
    u_if.ACK = 1'b1; idle(1); u_if.ACK = 1'b0;
  endtask

  task automatic test_reset();
    u_if.RX = 1'b1; u_if.ACK = 1'b0; RST = 1'b1;
    idle(3);
    n_cmp += 5;
    if (u_if.OUT !== 8'h00) begin n_err++; $display("FAIL rst_out: got %h want 00", u_if.OUT); end
    if (u_if.VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", u_if.VALID); end
    if (u_if.FERR !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b want 0", u_if.FERR); end
    if (u_if.OVR !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b want 0", u_if.OVR); end
    if (u_if.BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", u_if.BUSY); end
    RST = 1'b0;
    idle(10);
  endtask

  task automatic test_basic();
    int f0, o0;
    logic [7:0] exp;
    f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -1);
    exp = exp_q.pop_front();
    n_cmp += 5;
    if (u_if.OUT !== exp) begin n_err++; $display("FAIL basic_out: got %h want %h", u_if.OUT, exp); end
    if (u_if.VALID !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", u_if.VALID); end
    if (rise_cyc - e0_cyc != 990) begin n_err++; $display("FAIL basic_latency: got %0d want 990", rise_cyc - e0_cyc); end
    if (ferr_cnt != f0) begin n_err++; $display("FAIL basic_ferr: got %0d pulses want 0", ferr_cnt - f0); end
    if (ovr_cnt != o0) begin n_err++; $display("FAIL basic_ovr: got %0d pulses want 0", ovr_cnt - o0); end
    pulse_ack();
    idle(5);
  endtask

  task automatic test_back_to_back();
    int o0;
    logic [7:0] exp;
    o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, -1);
    exp = exp_q.pop_front();
    n_cmp++;
    if (u_if.OUT !== exp) begin n_err++; $display("FAIL b2b_first: got %h want %h", u_if.OUT, exp); end
    send_frame(8'h3C, 1'b1, -1);
    exp = exp_q.pop_front();
    n_cmp += 3;
    if (u_if.OUT !== exp) begin n_err++; $display("FAIL b2b_second: got %h want %h", u_if.OUT, exp); end
    if (u_if.VALID !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", u_if.VALID); end
    if (ovr_cnt - o0 != 1) begin n_err++; $display("FAIL b2b_ovr: got %0d pulses want 1", ovr_cnt - o0); end
    pulse_ack();
    n_cmp += 2;
    if (u_if.VALID !== 1'b0) begin n_err++; $display("FAIL b2b_ack_valid: got %b want 0", u_if.VALID); end
    if (u_if.OUT !== 8'h3C) begin n_err++; $display("FAIL b2b_ack_out: got %h want 3c", u_if.OUT); end
    idle(5);
  endtask

  task automatic test_glitch();
    int f0;
    logic [7:0] exp;
    f0 = ferr_cnt;
    u_if.RX = 1'b0;
    idle(10);
    n_cmp++;
    if (u_if.BUSY !== 1'b1) begin n_err++; $display("FAIL glitch_busy: got %b want 1", u_if.BUSY); end
    idle(10);
    u_if.RX = 1'b1;
    idle(100);
    n_cmp += 3;
    if (u_if.BUSY !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got busy %b want 0", u_if.BUSY); end
    if (u_if.VALID !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", u_if.VALID); end
    if (ferr_cnt != f0) begin n_err++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt - f0); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    exp = exp_q.pop_front();
    n_cmp += 2;
    if (u_if.OUT !== exp) begin n_err++; $display("FAIL glitch_next: got %h want %h", u_if.OUT, exp); end
    if (u_if.VALID !== 1'b1) begin n_err++; $display("FAIL glitch_next_valid: got %b want 1", u_if.VALID); end
    pulse_ack();
    idle(5);
  endtask

  task automatic test_framing();
    int f0, busy_hits;
    logic [7:0] exp;
    f0 = ferr_cnt;
    busy_hits = 0;
    send_frame(8'hFF, 1'b0, -1);
    for (int i = 0; i < 3 * DIV; i++) begin
      @(posedge CLK); #1;
      if (u_if.BUSY) busy_hits++;
    end
    n_cmp += 3;
    if (ferr_cnt - f0 != 1) begin n_err++; $display("FAIL ferr_pulse: got %0d pulses want 1", ferr_cnt - f0); end
    if (u_if.VALID !== 1'b0) begin n_err++; $display("FAIL ferr_valid: got %b want 0", u_if.VALID); end
    if (busy_hits != 0) begin n_err++; $display("FAIL ferr_break_start: got %0d busy cycles want 0", busy_hits); end
    u_if.RX = 1'b1;
    idle(20);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, -1);
    exp = exp_q.pop_front();
    n_cmp++;
    if (u_if.OUT !== exp) begin n_err++; $display("FAIL ferr_next: got %h want %h", u_if.OUT, exp); end
    pulse_ack();
    idle(5);
  endtask

  task automatic test_mid_reset();
    int f0, busy_hits;
    logic [7:0] b, exp;
    b = 8'hC3;  // bit 4 is 0, matching the low line held through reset
    busy_hits = 0;
    u_if.RX = 1'b0;
    idle(DIV);
    for (int k = 0; k < 4; k++) begin u_if.RX = b[k]; idle(DIV); end
    u_if.RX = 1'b0;
    idle(DIV / 2);
    RST = 1'b1;
    #2;
    n_cmp += 4;
    if (u_if.OUT !== 8'h00) begin n_err++; $display("FAIL mrst_out: got %h want 00", u_if.OUT); end
    if (u_if.VALID !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b want 0", u_if.VALID); end
    if (u_if.BUSY !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b want 0", u_if.BUSY); end
    if (u_if.FERR !== 1'b0 || u_if.OVR !== 1'b0) begin n_err++; $display("FAIL mrst_pulses: got ferr %b ovr %b want 0 0", u_if.FERR, u_if.OVR); end
    idle(3);
    RST = 1'b0;
    f0 = ferr_cnt;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(posedge CLK); #1;
      if (u_if.BUSY || u_if.VALID) busy_hits++;
    end
    n_cmp += 2;
    if (busy_hits != 0) begin n_err++; $display("FAIL mrst_low_line: got %0d active cycles want 0", busy_hits); end
    if (ferr_cnt != f0) begin n_err++; $display("FAIL mrst_ferr: got %0d pulses want 0", ferr_cnt - f0); end
    u_if.RX = 1'b1;
    idle(20);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, -1);
    exp = exp_q.pop_front();
    n_cmp += 2;
    if (u_if.OUT !== exp) begin n_err++; $display("FAIL mrst_next: got %h want %h", u_if.OUT, exp); end
    if (u_if.VALID !== 1'b1) begin n_err++; $display("FAIL mrst_next_valid: got %b want 1", u_if.VALID); end
    pulse_ack();
    idle(5);
  endtask

  task automatic test_ack_on_load();
    int o0;
    logic [7:0] exp;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    exp = exp_q.pop_front();
    n_cmp++;
    if (u_if.OUT !== exp) begin n_err++; $display("FAIL ackld_first: got %h want %h", u_if.OUT, exp); end
    idle(10);
    o0 = ovr_cnt;
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 990);
    exp = exp_q.pop_front();
    n_cmp += 3;
    if (u_if.OUT !== exp) begin n_err++; $display("FAIL ackld_out: got %h want %h", u_if.OUT, exp); end
    if (u_if.VALID !== 1'b1) begin n_err++; $display("FAIL ackld_valid: got %b want 1", u_if.VALID); end
    if (ovr_cnt != o0) begin n_err++; $display("FAIL ackld_ovr: got %0d pulses want 0", ovr_cnt - o0); end
    pulse_ack();
    idle(5);
  endtask

  initial begin
    u_if.RX  = 1'b1;
    u_if.ACK = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_mid_reset();
    test_ack_on_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
